// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared state/mode encodings and filter counter sizing
package edge_detect_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    RISE = 2'b01,
    ONE  = 2'b10,
    FALL = 2'b11
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold 0..filt_cyc; never narrower than one bit.
  function automatic int cnt_width(input int filt_cyc);
    return (filt_cyc < 1) ? 1 : $clog2(filt_cyc + 1);
  endfunction

endpackage

// File: rtl/edge_detect_multi_amisha_if.sv
// rtl/edge_detect_multi_amisha_if.sv - level/mode/clear in, event pulses and flags out
interface edge_detect_multi_amisha_if #(
  parameter int NCH = 1
);
  logic [NCH-1:0]   level;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic [NCH-1:0]   flag;

  modport master (output level, mode, clr, input tick, rise, fall, flag);
  modport slave  (input level, mode, clr, output tick, rise, fall, flag);
endinterface

// File: rtl/edge_detect_multi_amisha_chan.sv
// rtl/edge_detect_multi_amisha_chan.sv - one channel: optional sync (EDGE_DETECT_SYNC_EN), glitch filter, edge FSM, sticky flag
module edge_detect_chan_amisha
  import edge_detect_pkg::*;
#(
  parameter int FILT_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  edge_detect_multi_amisha_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(FILT_CYC);
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_CYC);

  logic             sample;
  logic             f;
  logic [CNT_W-1:0] cnt;
  state_t           state_q;
  state_t           state_d;
  logic             tick;
  logic             flag;
  logic [1:0]       mode;

  assign mode = bus.mode[1:0];

`ifdef EDGE_DETECT_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], bus.level[0]};
    end
  end

  assign sample = sync[1];
`else
  assign sample = bus.level[0];
`endif

  // A new level is taken only after FILT_CYC+1 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (sample == f) begin
      cnt <= '0;
    end else if (cnt == FILT_MAX) begin
      f   <= sample;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ZERO;
    case (state_q)
      ZERO:    state_d = f ? RISE : ZERO;
      RISE:    state_d = f ? ONE  : FALL;
      ONE:     state_d = f ? ONE  : FALL;
      FALL:    state_d = f ? RISE : ZERO;
      default: state_d = ZERO;
    endcase
  end

  assign bus.rise = (state_q == RISE);
  assign bus.fall = (state_q == FALL);

  assign tick = (bus.rise[0] && (mode == MODE_RISE || mode == MODE_BOTH)) ||
                (bus.fall[0] && (mode == MODE_FALL || mode == MODE_BOTH));
  assign bus.tick = tick;

  // Set has priority over clear so an event coinciding with a clear is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else begin
      flag <= tick | (flag & ~bus.clr[0]);
    end
  end

  assign bus.flag = flag;

endmodule

// File: rtl/edge_detect_multi_amisha.sv
// rtl/edge_detect_multi_amisha.sv - NCH independent edge-detect channels; EDGE_DETECT_SYNC_EN adds input synchronisers
module edge_detect_multi_amisha
  import edge_detect_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int FILT_CYC = 2
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic [NCH-1:0]   level_amisha,
  input  logic [2*NCH-1:0] mode_amisha,
  input  logic [NCH-1:0]   clr_amisha,
  output logic [NCH-1:0]   tick_amisha,
  output logic [NCH-1:0]   rise_amisha,
  output logic [NCH-1:0]   fall_amisha,
  output logic [NCH-1:0]   flag_amisha
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_detect_multi_amisha_if #(.NCH(1)) ch_bus ();

    assign ch_bus.level = level_amisha[i];
    assign ch_bus.mode  = mode_amisha[2*i +: 2];
    assign ch_bus.clr   = clr_amisha[i];

    edge_detect_chan_amisha #(
      .FILT_CYC(FILT_CYC)
    ) u_chan (
      .clk   (clk_amisha),
      .rst_n (reset_n_amisha),
      .bus   (ch_bus.slave)
    );

    assign tick_amisha[i] = ch_bus.tick[0];
    assign rise_amisha[i] = ch_bus.rise[0];
    assign fall_amisha[i] = ch_bus.fall[0];
    assign flag_amisha[i] = ch_bus.flag[0];
  end

endmodule

// File: tb/tb_edge_detect_multi_amisha.sv
// tb/tb_edge_detect_multi_amisha.sv - checks FILT_CYC=2 and FILT_CYC=0 builds against a sample-window reference model
module tb_edge_detect_multi_amisha;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edge_detect_multi_amisha_if #(.NCH(4)) bus2 ();
  edge_detect_multi_amisha_if #(.NCH(4)) bus0 ();

  assign bus0.level = bus2.level;
  assign bus0.mode  = bus2.mode;
  assign bus0.clr   = bus2.clr;

  edge_detect_multi_amisha #(.NCH(4), .FILT_CYC(2)) dut2 (
    .clk_amisha(clk), .reset_n_amisha(rst_n),
    .level_amisha(bus2.level), .mode_amisha(bus2.mode), .clr_amisha(bus2.clr),
    .tick_amisha(bus2.tick), .rise_amisha(bus2.rise), .fall_amisha(bus2.fall),
    .flag_amisha(bus2.flag));

  edge_detect_multi_amisha #(.NCH(4), .FILT_CYC(0)) dut0 (
    .clk_amisha(clk), .reset_n_amisha(rst_n),
    .level_amisha(bus0.level), .mode_amisha(bus0.mode), .clr_amisha(bus0.clr),
    .tick_amisha(bus0.tick), .rise_amisha(bus0.rise), .fall_amisha(bus0.fall),
    .flag_amisha(bus0.flag));

  int checks = 0;
  int failures = 0;

  // Model: accepted level per channel, its two previous values, and the raw sample history.
  logic       mf    [2][4];
  logic       mf1   [2][4];
  logic       mf2   [2][4];
  logic       mflag [2][4];
  logic       sy1   [2][4];
  logic       sy2   [2][4];
  logic [7:0] hist  [2][4];
  int         nv    [2][4];
  logic [3:0] etick [2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int filt_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        mf[d][c] = 0; mf1[d][c] = 0; mf2[d][c] = 0; mflag[d][c] = 0;
        sy1[d][c] = 0; sy2[d][c] = 0; hist[d][c] = '0; nv[d][c] = 0;
      end
      etick[d] = '0;
    end
  endtask

  task automatic check_outputs(input logic [7:0] m);
    logic [3:0] er, ef, et, efl;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        er[c]  = mf1[d][c] & ~mf2[d][c];
        ef[c]  = mf2[d][c] & ~mf1[d][c];
        et[c]  = (er[c] & m[2*c]) | (ef[c] & m[2*c+1]);
        efl[c] = mflag[d][c];
      end
      etick[d] = et;
      chk($sformatf("d%0d_tick", d), (d == 0) ? bus2.tick : bus0.tick, et);
      chk($sformatf("d%0d_rise", d), (d == 0) ? bus2.rise : bus0.rise, er);
      chk($sformatf("d%0d_fall", d), (d == 0) ? bus2.fall : bus0.fall, ef);
      chk($sformatf("d%0d_flag", d), (d == 0) ? bus2.flag : bus0.flag, efl);
    end
  endtask

  // Called at a negedge: drive, advance model on the posedge, check 1 ns later, return at next negedge.
  task automatic step(input logic [3:0] l, input logic [7:0] m, input logic [3:0] c);
    logic s, tk, acc;
    int n;
    bus2.level = l; bus2.mode = m; bus2.clr = c;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        tk = (mf1[d][ch] & ~mf2[d][ch] & m[2*ch]) | (mf2[d][ch] & ~mf1[d][ch] & m[2*ch+1]);
        mflag[d][ch] = tk | (mflag[d][ch] & ~c[ch]);
`ifdef EDGE_DETECT_SYNC_EN
        s = sy2[d][ch]; sy2[d][ch] = sy1[d][ch]; sy1[d][ch] = l[ch];
`else
        s = l[ch];
`endif
        mf2[d][ch] = mf1[d][ch];
        mf1[d][ch] = mf[d][ch];
        hist[d][ch] = {hist[d][ch][6:0], s};
        if (nv[d][ch] < 8) nv[d][ch]++;
        n = filt_of(d) + 1;
        acc = (nv[d][ch] >= n);
        for (int k = 0; k < n; k++) if (hist[d][ch][k] == mf[d][ch]) acc = 0;
        if (acc) mf[d][ch] = ~mf[d][ch];
      end
    end
    #1;
    check_outputs(m);
    @(negedge clk);
  endtask

  // Called at a negedge: asserts reset off any clock edge, checks outputs clear at once, releases at a negedge.
  task automatic async_reset(input logic [3:0] l);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_tick", {bus2.tick, bus0.tick}, 8'h00);
    chk("rst_rise", {bus2.rise, bus0.rise}, 8'h00);
    chk("rst_fall", {bus2.fall, bus0.fall}, 8'h00);
    chk("rst_flag", {bus2.flag, bus0.flag}, 8'h00);
    model_reset();
    bus2.level = l; bus2.clr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] lv, cl;
    logic [7:0] md;
    int first, first_tick, exp_lat;
    bit seen;

    model_reset();
    bus2.level = '0; bus2.mode = 8'hFF; bus2.clr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset, then level high across a reset release.
    for (int i = 0; i < 20; i++) step(4'h0, 8'hFF, 4'h0);
    async_reset(4'hF);
    for (int i = 0; i < 8; i++) step(4'hF, 8'hFF, 4'h0);
    for (int i = 0; i < 8; i++) step(4'h0, 8'hFF, 4'h0);

    // Channel 0 rise-only latency, then a fall that must not tick.
`ifdef EDGE_DETECT_SYNC_EN
    exp_lat = 6;
`else
    exp_lat = 4;
`endif
    first = 0; first_tick = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'h1, 8'h01, 4'h0);
      if (first == 0 && bus2.rise[0]) first = i;
      if (first_tick == 0 && bus2.tick[0]) first_tick = i;
    end
    chk("ch0_rise_lat", 8'(first), 8'(exp_lat));
    chk("ch0_tick_lat", 8'(first_tick), 8'(exp_lat));
    for (int i = 0; i < 10; i++) step(4'h0, 8'h01, 4'h0);

    // Channel 1: two-cycle glitch, then three-cycle pulse.
    for (int i = 0; i < 2; i++) step(4'h2, 8'hFF, 4'h0);
    for (int i = 0; i < 8; i++) step(4'h0, 8'hFF, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h2, 8'hFF, 4'h0);
    for (int i = 0; i < 10; i++) step(4'h0, 8'hFF, 4'h0);

    // Channel 2 toggling every cycle.
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'h4 : 4'h0, 8'hFF, 4'h0);
    for (int i = 0; i < 8; i++) step(4'h0, 8'hFF, 4'h0);

    // Channel 3: clear coinciding with a tick, then a lone clear.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(4'h8, 8'hFF, 4'h0);
      seen = etick[0][3];
    end
    chk("ch3_tick_seen", 8'(seen), 8'h01);
    step(4'h8, 8'hFF, 4'h8);
    chk("ch3_set_wins", 8'(bus2.flag[3]), 8'h01);
    step(4'h8, 8'hFF, 4'h8);
    chk("ch3_clr", 8'(bus2.flag[3]), 8'h00);
    for (int i = 0; i < 6; i++) step(4'h0, 8'hFF, 4'h0);

    // Reset while every filter is part way through a change.
    step(4'hF, 8'hFF, 4'h0);
    async_reset(4'h0);
    for (int i = 0; i < 12; i++) step(4'h0, 8'hFF, 4'h0);

    // Randomised traffic with occasional resets.
    lv = '0; md = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) lv[c] = ~lv[c];
      if ($urandom_range(0, 15) == 0) md = 8'($urandom);
      cl = '0;
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 7) == 0) cl[c] = 1'b1;
      if ($urandom_range(0, 149) == 0) async_reset(lv);
      else step(lv, md, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi_amisha.md
Name: edge_detect_multi_amisha

Overview:
- Multi-channel, parametrised edge detector built from one Moore FSM per channel.
- Each channel filters its input level for glitches and detects rising, falling or both edges, selected per channel at run time.
- Each channel produces a one-cycle registered-decode tick and a sticky event flag.
- Sits between raw level sources (buttons, status lines) and FSM/interrupt logic that consumes single-cycle events.

Parameters:
- NCH, 4, number of independent channels (>=1).
- FILT_CYC, 2, input level must differ from the accepted level for FILT_CYC+1 consecutive samples before it is accepted; 0 = no filtering, one register stage only.
- CNT_W, $clog2(FILT_CYC+1) clamped to min 1, width of the per-channel filter counter (derived; not overridden).

Ports:
- clk_amisha  in  1  system clock, all logic on rising edge
- reset_n_amisha  in  1  asynchronous, active-low reset
- level_amisha  in  NCH  raw input levels, one bit per channel
- mode_amisha  in  2*NCH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clr_amisha  in  NCH  per-channel sticky-flag clear, one-cycle pulse
- tick_amisha  out  NCH  one-cycle event pulse per channel, qualified by mode
- rise_amisha  out  NCH  one-cycle pulse on any accepted rising edge, ignores mode
- fall_amisha  out  NCH  one-cycle pulse on any accepted falling edge, ignores mode
- flag_amisha  out  NCH  sticky event flag, set by tick, cleared by clr

Behaviour:
- Reset: async assert while reset_n_amisha=0. All FSMs go to ZERO; filtered level, filter counters and flags go to 0. All outputs are 0 during reset.
- Filter, per channel, registered f and cnt:
  - level==f -> cnt<=0.
  - level!=f and cnt!=FILT_CYC -> cnt<=cnt+1.
  - level!=f and cnt==FILT_CYC -> f<=level, cnt<=0.
  - A pulse of FILT_CYC or fewer cycles is rejected. A change is accepted at the clock edge FILT_CYC+1 samples after the first differing sample.
- FSM states, 2-bit: ZERO, RISE, ONE, FALL. Transitions on f:
  - ZERO: f=1 -> RISE, else stay.
  - RISE: f=1 -> ONE, f=0 -> FALL.
  - ONE: f=0 -> FALL, else stay.
  - FALL: f=1 -> RISE, f=0 -> ZERO.
  - Illegal/default state -> ZERO.
- Outputs are Moore, decoded from the state register only:
  - rise = (state==RISE); fall = (state==FALL).
  - tick = (rise & mode[0]) | (fall & mode[1]).
- Latency: level changes and is held from edge k. f updates at edge k+FILT_CYC. tick/rise/fall are high for exactly the one cycle following edge k+FILT_CYC+1.
- With FILT_CYC=0, alternating input every cycle yields alternating rise/fall pulses; no edge is ever lost.
- Mode changes affect tick decode immediately, combinationally from the registered mode input. FSM state is unaffected; mode=00 suppresses tick but not rise/fall.
- flag: set when tick=1, cleared when clr=1. Simultaneous tick and clr -> flag stays/becomes 1 (set wins). Clear latency is 1 cycle.
- Level already high at reset release produces one rise after FILT_CYC+2 cycles. This is intended.
- Reset mid-filter or mid-pulse aborts it; no tick is emitted after release until a fresh accepted change.
- Channels are fully independent; no cross-channel priority.

Optional Feature:
- Macro EDGE_DETECT_SYNC_EN.
- Defined: a 2-flop synchroniser per channel, reset to 0, precedes the filter. Inputs may be asynchronous; all latencies grow by 2 cycles.
- Undefined: level_amisha is assumed synchronous to clk_amisha and feeds the filter directly.

Decomposition:
- Package edge_detect_pkg:
  - state encodings ZERO=2'b00, RISE=2'b01, ONE=2'b10, FALL=2'b11;
  - mode constants MODE_OFF/RISE/FALL/BOTH;
  - filter counter width function.
- Sub-module edge_detect_chan_amisha: one channel containing optional sync, filter, FSM and flag. The top instantiates it NCH times in a generate loop and slices mode/level/clr.

Test Plan:
- Reset release with all levels 0, mode=11 -> all outputs 0 for 20 cycles; level high at release produces rise after FILT_CYC+2 cycles.
- FILT_CYC=2, ch0 mode=01, level 0->1 held from edge 10 -> f updates at edge 12; tick0 and rise0 high only in the cycle after edge 13; falling edge later gives fall0=1 and tick0=0.
- FILT_CYC=2, 2-cycle glitch on ch1 -> no rise/fall/tick. 3-cycle pulse -> one rise then, 3 cycles after level returns low, one fall.
- FILT_CYC=0, ch2 mode=11, level toggling every cycle for 8 cycles -> tick2 high 8 consecutive cycles, alternating rise2/fall2.
- ch3 tick and clr3 in the same cycle -> flag3=1; clr3 alone next cycle -> flag3=0 the following cycle.
- reset_n_amisha pulsed low mid-filter (cnt=1) on all channels -> outputs and flags clear immediately, asynchronously; no spurious tick after release with level=0.
